// File: rtl/mac_job_scheduler.sv
// ---------------------------------------------------------------------------
// mac_job_scheduler: round-robin sharing of one MAC accelerator among requesters
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module mac_job_scheduler #(
  parameter  int WIDTH   = 16,
  parameter  int NREQ    = 4,
  parameter  int MAX_LEN = 16,
  localparam int LENW    = $clog2(MAX_LEN + 1),
  localparam int IDW     = $clog2(NREQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           job_req_i,
  input  logic [NREQ*LENW-1:0]      job_len_i,
  output logic [NREQ-1:0]           job_grant_o,
  input  logic [NREQ-1:0]           op_valid_i,
  input  logic [NREQ*WIDTH-1:0]     op_a_i,
  input  logic [NREQ*WIDTH-1:0]     op_b_i,
  output logic [NREQ-1:0]           op_ready_o,
  output logic                      res_valid_o,
  output logic [IDW-1:0]            res_id_o,
  output logic signed [2*WIDTH-1:0] res_data_o,
  input  logic                      res_ready_i,
  output logic                      acc_wr_en_o,
  output logic [WIDTH-1:0]          acc_din_a_o,
  output logic [WIDTH-1:0]          acc_din_b_o,
  input  logic                      acc_fifo_full_i,
  output logic                      acc_clr_o,
  input  logic signed [2*WIDTH-1:0] acc_out_i,
  input  logic                      acc_valid_out_i
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_STREAM = 3'd2,
    S_DRAIN  = 3'd3,
    S_RESULT = 3'd4
  } state_t;

  state_t                    state_q, state_d;
  logic [IDW-1:0]            rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]            cur_id_q, cur_id_d;
  logic [LENW-1:0]           cur_len_q, cur_len_d;
  logic [LENW-1:0]           sent_q, sent_d;
  logic [LENW-1:0]           done_q, done_d;
  logic signed [2*WIDTH-1:0] res_data_q, res_data_d;
  logic [NREQ-1:0]           grant_q, grant_d;
  logic                      clr_q, clr_d;

  logic [LENW-1:0]  w_len [NREQ];
  logic [WIDTH-1:0] w_opa [NREQ];
  logic [WIDTH-1:0] w_opb [NREQ];
  logic             w_arb_found;
  logic [IDW-1:0]   w_arb_id;
  logic [IDW-1:0]   w_cand;
  logic             w_ready;

  genvar gi;
  for (gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign w_len[gi] = job_len_i[gi*LENW +: LENW];
    assign w_opa[gi] = op_a_i[gi*WIDTH +: WIDTH];
    assign w_opb[gi] = op_b_i[gi*WIDTH +: WIDTH];
  end

  // Scan downward so the last hit written is the first requester at/after rr_ptr.
  always_comb begin
    w_arb_found = 1'b0;
    w_arb_id    = '0;
    w_cand      = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_cand = IDW'((int'(rr_ptr_q) + k) % NREQ);
      if (job_req_i[w_cand]) begin
        w_arb_found = 1'b1;
        w_arb_id    = w_cand;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    cur_id_d    = cur_id_q;
    cur_len_d   = cur_len_q;
    sent_d      = sent_q;
    done_d      = done_q;
    res_data_d  = res_data_q;
    grant_d     = '0;
    clr_d       = 1'b0;
    w_ready     = 1'b0;
    op_ready_o  = '0;
    acc_wr_en_o = 1'b0;
    acc_din_a_o = '0;
    acc_din_b_o = '0;
    res_valid_o = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (w_arb_found) begin
          grant_d   = NREQ'(1) << w_arb_id;
          cur_id_d  = w_arb_id;
          cur_len_d = w_len[w_arb_id];
          rr_ptr_d  = (int'(w_arb_id) == NREQ - 1) ? '0 : w_arb_id + 1'b1;
          state_d   = S_CLEAR;
        end
      end
      S_CLEAR: begin
        clr_d  = 1'b1;
        sent_d = '0;
        done_d = '0;
        if (cur_len_q == '0) begin
          res_data_d = '0;
          state_d    = S_RESULT;
        end else begin
          state_d = S_STREAM;
        end
      end
      S_STREAM: begin
        // Hold off while the clear pulse is on the wire so it lands before any write.
        w_ready              = !acc_fifo_full_i && !clr_q && (sent_q < cur_len_q);
        op_ready_o[cur_id_q] = w_ready;
        if (w_ready && op_valid_i[cur_id_q]) begin
          acc_wr_en_o = 1'b1;
          acc_din_a_o = w_opa[cur_id_q];
          acc_din_b_o = w_opb[cur_id_q];
          sent_d      = sent_q + 1'b1;
        end
        if (sent_d == cur_len_q) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
      end
      S_RESULT: begin
        res_valid_o = 1'b1;
        if (res_ready_i) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if ((state_q == S_STREAM || state_q == S_DRAIN) && acc_valid_out_i) begin
      done_d = done_q + 1'b1;
      if (done_d == cur_len_q) begin
        res_data_d = acc_out_i;
        state_d    = S_RESULT;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      rr_ptr_q   <= '0;
      cur_id_q   <= '0;
      cur_len_q  <= '0;
      sent_q     <= '0;
      done_q     <= '0;
      res_data_q <= '0;
      grant_q    <= '0;
      clr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      cur_id_q   <= cur_id_d;
      cur_len_q  <= cur_len_d;
      sent_q     <= sent_d;
      done_q     <= done_d;
      res_data_q <= res_data_d;
      grant_q    <= grant_d;
      clr_q      <= clr_d;
    end
  end

  assign job_grant_o = grant_q;
  assign acc_clr_o   = clr_q;
  assign res_id_o    = cur_id_q;
  assign res_data_o  = res_data_q;

endmodule

`default_nettype wire

// File: tb/tb_mac_job_scheduler.sv
// ---------------------------------------------------------------------------
// tb_mac_job_scheduler: scoreboard bench with a behavioural FIFO+MAC accelerator
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_mac_job_scheduler;
  localparam int WIDTH   = 16;
  localparam int NREQ    = 4;
  localparam int MAX_LEN = 16;
  localparam int LENW    = 5;
  localparam int IDW     = 2;

  logic                      clk = 1'b0;
  logic                      rst_n = 1'b0;
  logic [NREQ-1:0]           job_req = '0;
  logic [NREQ*LENW-1:0]      job_len = '0;
  logic [NREQ-1:0]           job_grant;
  logic [NREQ-1:0]           op_valid = '0;
  logic [NREQ*WIDTH-1:0]     op_a = '0;
  logic [NREQ*WIDTH-1:0]     op_b = '0;
  logic [NREQ-1:0]           op_ready;
  logic                      res_valid;
  logic [IDW-1:0]            res_id;
  logic signed [2*WIDTH-1:0] res_data;
  logic                      res_ready = 1'b1;
  logic                      acc_wr_en;
  logic [WIDTH-1:0]          acc_din_a, acc_din_b;
  logic                      acc_fifo_full;
  logic                      acc_clr;
  logic signed [2*WIDTH-1:0] acc_out;
  logic                      acc_valid_out;

  mac_job_scheduler #(.WIDTH(WIDTH), .NREQ(NREQ), .MAX_LEN(MAX_LEN)) dut (
    .clk(clk), .rst_n(rst_n),
    .job_req_i(job_req), .job_len_i(job_len), .job_grant_o(job_grant),
    .op_valid_i(op_valid), .op_a_i(op_a), .op_b_i(op_b), .op_ready_o(op_ready),
    .res_valid_o(res_valid), .res_id_o(res_id), .res_data_o(res_data), .res_ready_i(res_ready),
    .acc_wr_en_o(acc_wr_en), .acc_din_a_o(acc_din_a), .acc_din_b_o(acc_din_b),
    .acc_fifo_full_i(acc_fifo_full), .acc_clr_o(acc_clr),
    .acc_out_i(acc_out), .acc_valid_out_i(acc_valid_out)
  );

  always #5 clk = ~clk;

  // Accelerator model: 4-deep operand FIFO, one multiply stage, accumulate stage.
  logic [31:0]        mf [4];
  logic [2:0]         m_wp, m_rp;
  logic               m_p1_v, m_valid_r;
  logic signed [31:0] m_p1_prod, m_acc;
  bit                 force_full = 1'b0;

  function automatic logic signed [31:0] mulp(input logic [31:0] p);
    logic signed [31:0] a, b;
    a = {{16{p[31]}}, p[31:16]};
    b = {{16{p[15]}}, p[15:0]};
    return a * b;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_wp <= '0; m_rp <= '0; m_p1_v <= 1'b0; m_p1_prod <= '0; m_acc <= '0; m_valid_r <= 1'b0;
    end else begin
      if (acc_wr_en) begin
        mf[m_wp[1:0]] <= {acc_din_a, acc_din_b};
        m_wp          <= m_wp + 3'd1;
      end
      if (m_wp != m_rp) begin
        m_p1_v    <= 1'b1;
        m_p1_prod <= mulp(mf[m_rp[1:0]]);
        m_rp      <= m_rp + 3'd1;
      end else begin
        m_p1_v <= 1'b0;
      end
      m_valid_r <= m_p1_v;
      if (acc_clr) m_acc <= '0;
      else if (m_p1_v) m_acc <= m_acc + m_p1_prod;
    end
  end

  assign acc_out       = m_acc;
  assign acc_valid_out = m_valid_r;
  assign acc_fifo_full = (3'(m_wp - m_rp) == 3'd4) || force_full;

  // Requester-side state and scoreboard
  typedef struct {int id; logic [31:0] data;} exp_t;
  exp_t exp_q[$];
  logic signed [15:0] opa [NREQ][MAX_LEN];
  logic signed [15:0] opb [NREQ][MAX_LEN];
  int  jlen [NREQ];
  int  idx [NREQ];
  bit  active [NREQ];
  int  n_checks = 0, n_pass = 0;
  int  cyc = 0, wr_cnt = 0, clr_cnt = 0, full_bad = 0;
  int  first_wr_cyc = 0, clr_cyc = 0, grant_cyc = 0, rv_cyc = 0;
  bit  rv_seen = 1'b0, got_res = 1'b0, res_ready_en = 1'b1;
  int  got_id = 0;
  logic [31:0] got_data = '0;
  int  grant_log[$];

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      bit v;
      v = active[i] && (idx[i] < jlen[i]);
      op_valid[i] = v;
      op_a[i*WIDTH +: WIDTH] = v ? opa[i][idx[i]] : '0;
      op_b[i*WIDTH +: WIDTH] = v ? opb[i][idx[i]] : '0;
      job_len[i*LENW +: LENW] = LENW'(jlen[i]);
    end
    res_ready = res_ready_en;
  endtask

  task automatic tick();
    logic [NREQ-1:0] xf;
    @(posedge clk);
    cyc++;
    xf = op_valid & op_ready;
    if (acc_wr_en) begin
      if (wr_cnt == 0) first_wr_cyc = cyc - 1;
      wr_cnt++;
      if (acc_fifo_full) full_bad++;
    end
    if (acc_fifo_full && op_ready != '0) full_bad++;
    if (acc_clr) begin clr_cnt++; clr_cyc = cyc - 1; end
    if (res_valid && res_ready) begin
      got_res = 1'b1; got_id = int'(res_id); got_data = res_data; active[res_id] = 1'b0;
    end
    #1;
    for (int i = 0; i < NREQ; i++) if (xf[i]) idx[i]++;
    for (int i = 0; i < NREQ; i++) begin
      if (job_grant[i]) begin
        job_req[i] = 1'b0; active[i] = 1'b1; idx[i] = 0;
        grant_log.push_back(i); grant_cyc = cyc;
      end
    end
    if (res_valid && !rv_seen) begin rv_seen = 1'b1; rv_cyc = cyc; end
    drive();
  endtask

  task automatic submit(input int id, input int len);
    int s;
    s = 0;
    for (int k = 0; k < len; k++) s += int'(opa[id][k]) * int'(opb[id][k]);
    exp_q.push_back('{id, 32'(s)});
    jlen[id] = len;
    job_req[id] = 1'b1;
    drive();
  endtask

  task automatic wait_result(output bit ok);
    got_res = 1'b0;
    for (int n = 0; n < 300 && !got_res; n++) tick();
    ok = got_res;
  endtask

  task automatic test_reset();
    repeat (3) tick();
    n_checks++; if (job_grant !== '0) $display("FAIL rst_grant: got %0h want 0", job_grant); else n_pass++;
    n_checks++; if (op_ready !== '0) $display("FAIL rst_op_ready: got %0h want 0", op_ready); else n_pass++;
    n_checks++; if ({res_valid, res_id, res_data} !== '0) $display("FAIL rst_res: got v=%0d id=%0d d=%0h want 0", res_valid, res_id, res_data); else n_pass++;
    n_checks++; if ({acc_wr_en, acc_din_a, acc_din_b, acc_clr} !== '0) $display("FAIL rst_acc: got wr=%0d a=%0h b=%0h clr=%0d want 0", acc_wr_en, acc_din_a, acc_din_b, acc_clr); else n_pass++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_round_robin();
    bit ok;
    exp_t e;
    int exp_g[5] = '{0, 1, 2, 3, 0};
    grant_log.delete();
    for (int i = 0; i < NREQ; i++) begin
      opa[i][0] = 16'(i + 1); opb[i][0] = 16'sd10;
      submit(i, 1);
    end
    for (int n = 0; n < 5; n++) begin
      wait_result(ok);
      n_checks++; if (!ok) $display("FAIL rr_timeout: got no result want result %0d", n); else n_pass++;
      e = exp_q.pop_front();
      n_checks++; if (got_id !== e.id || got_data !== e.data) $display("FAIL rr_result: got id=%0d d=%0h want id=%0d d=%0h", got_id, got_data, e.id, e.data); else n_pass++;
      if (n == 0) begin
        opa[0][0] = -16'sd4; opb[0][0] = 16'sd9;
        submit(0, 1);
      end
    end
    n_checks++; if (grant_log.size() != 5) $display("FAIL rr_grant_count: got %0d want 5", grant_log.size()); else n_pass++;
    for (int n = 0; n < 5 && n < grant_log.size(); n++) begin
      n_checks++; if (grant_log[n] != exp_g[n]) $display("FAIL rr_order[%0d]: got %0d want %0d", n, grant_log[n], exp_g[n]); else n_pass++;
    end
  endtask

  task automatic test_single();
    bit ok;
    exp_t e;
    wr_cnt = 0; clr_cnt = 0; rv_seen = 1'b0;
    opa[0][0] = 16'sd1; opa[0][1] = 16'sd2; opa[0][2] = 16'sd3;
    opb[0][0] = 16'sd4; opb[0][1] = 16'sd5; opb[0][2] = 16'sd6;
    submit(0, 3);
    wait_result(ok);
    n_checks++; if (!ok) $display("FAIL single_timeout: got no result want result"); else n_pass++;
    e = exp_q.pop_front();
    n_checks++; if (got_id !== e.id || got_data !== e.data) $display("FAIL single_result: got id=%0d d=%0h want id=%0d d=%0h", got_id, got_data, e.id, e.data); else n_pass++;
    n_checks++; if (got_data !== 32'd32) $display("FAIL single_value: got %0d want 32", got_data); else n_pass++;
    n_checks++; if (wr_cnt != 3 || clr_cnt != 1) $display("FAIL single_pulses: got wr=%0d clr=%0d want wr=3 clr=1", wr_cnt, clr_cnt); else n_pass++;
    n_checks++; if (clr_cyc != grant_cyc + 1 || first_wr_cyc != clr_cyc + 1) $display("FAIL single_order: got grant=%0d clr=%0d wr=%0d want clr=grant+1 wr=clr+1", grant_cyc, clr_cyc, first_wr_cyc); else n_pass++;
    n_checks++; if (rv_cyc - grant_cyc != 3 + 5) $display("FAIL single_latency: got %0d want 8", rv_cyc - grant_cyc); else n_pass++;
  endtask

  task automatic test_signed();
    bit ok;
    exp_t e;
    opa[2][0] = -16'sd2; opa[2][1] = 16'sd7;
    opb[2][0] = 16'sd3;  opb[2][1] = -16'sd1;
    submit(2, 2);
    wait_result(ok);
    n_checks++; if (!ok) $display("FAIL signed_timeout: got no result want result"); else n_pass++;
    e = exp_q.pop_front();
    n_checks++; if (got_id !== e.id || got_data !== e.data) $display("FAIL signed_result: got id=%0d d=%0h want id=%0d d=%0h", got_id, got_data, e.id, e.data); else n_pass++;
    n_checks++; if (got_data !== 32'hFFFF_FFF3) $display("FAIL signed_value: got %0h want fffffff3", got_data); else n_pass++;
  endtask

  task automatic test_zero_len();
    bit ok;
    exp_t e;
    wr_cnt = 0; clr_cnt = 0;
    submit(1, 0);
    wait_result(ok);
    n_checks++; if (!ok) $display("FAIL zero_timeout: got no result want result"); else n_pass++;
    e = exp_q.pop_front();
    n_checks++; if (got_id !== e.id || got_data !== 32'd0) $display("FAIL zero_result: got id=%0d d=%0h want id=%0d d=0", got_id, got_data, e.id); else n_pass++;
    n_checks++; if (wr_cnt != 0 || clr_cnt != 1) $display("FAIL zero_pulses: got wr=%0d clr=%0d want wr=0 clr=1", wr_cnt, clr_cnt); else n_pass++;
  endtask

  task automatic test_backpressure();
    bit ok;
    exp_t e;
    int bad, n;
    logic [IDW-1:0] sid;
    logic [31:0] sdat;
    wr_cnt = 0; full_bad = 0; res_ready_en = 1'b0;
    for (int k = 0; k < 6; k++) begin
      opa[3][k] = 16'sh7FFF; opb[3][k] = 16'(16'sh7FFF - 16'(k));
    end
    submit(3, 6);
    for (n = 0; n < 100 && wr_cnt < 2; n++) tick();
    force_full = 1'b1;
    repeat (5) tick();
    force_full = 1'b0;
    for (n = 0; n < 100 && !res_valid; n++) tick();
    n_checks++; if (!res_valid) $display("FAIL bp_timeout: got res_valid=0 want 1"); else n_pass++;
    sid = res_id; sdat = res_data; bad = 0;
    repeat (4) begin
      tick();
      if (!res_valid || res_id !== sid || res_data !== sdat) bad++;
    end
    n_checks++; if (bad != 0) $display("FAIL bp_stable: got %0d unstable cycles want 0", bad); else n_pass++;
    res_ready_en = 1'b1;
    drive();
    wait_result(ok);
    n_checks++; if (!ok) $display("FAIL bp_handshake: got no result want result"); else n_pass++;
    e = exp_q.pop_front();
    n_checks++; if (got_id !== e.id || got_data !== e.data) $display("FAIL bp_result: got id=%0d d=%0h want id=%0d d=%0h", got_id, got_data, e.id, e.data); else n_pass++;
    n_checks++; if (wr_cnt != 6 || full_bad != 0) $display("FAIL bp_writes: got wr=%0d while_full=%0d want wr=6 while_full=0", wr_cnt, full_bad); else n_pass++;
  endtask

  task automatic test_reset_midstream();
    bit ok;
    exp_t e;
    int n;
    wr_cnt = 0;
    for (int k = 0; k < 5; k++) begin opa[1][k] = 16'(k + 2); opb[1][k] = 16'sd3; end
    submit(1, 5);
    for (n = 0; n < 100 && wr_cnt < 2; n++) tick();
    n_checks++; if (wr_cnt != 2) $display("FAIL mid_sent: got %0d want 2", wr_cnt); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++; if (job_grant !== '0 || op_ready !== '0 || acc_clr !== 1'b0) $display("FAIL mid_rst_ctrl: got g=%0h r=%0h clr=%0d want 0", job_grant, op_ready, acc_clr); else n_pass++;
    n_checks++; if ({res_valid, res_id, res_data} !== '0) $display("FAIL mid_rst_res: got v=%0d id=%0d d=%0h want 0", res_valid, res_id, res_data); else n_pass++;
    n_checks++; if ({acc_wr_en, acc_din_a, acc_din_b} !== '0) $display("FAIL mid_rst_acc: got wr=%0d a=%0h b=%0h want 0", acc_wr_en, acc_din_a, acc_din_b); else n_pass++;
    void'(exp_q.pop_back());
    for (int i = 0; i < NREQ; i++) begin active[i] = 1'b0; job_req[i] = 1'b0; jlen[i] = 0; end
    drive();
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    opa[0][0] = 16'sd3; opb[0][0] = 16'sd3;
    submit(0, 1);
    wait_result(ok);
    n_checks++; if (!ok) $display("FAIL mid_timeout: got no result want result"); else n_pass++;
    e = exp_q.pop_front();
    n_checks++; if (got_id !== 0 || got_data !== e.data || got_data !== 32'd9) $display("FAIL mid_result: got id=%0d d=%0d want id=0 d=9", got_id, got_data); else n_pass++;
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) begin
      jlen[i] = 0; idx[i] = 0; active[i] = 1'b0;
      for (int k = 0; k < MAX_LEN; k++) begin opa[i][k] = '0; opb[i][k] = '0; end
    end
    test_reset();
    test_round_robin();
    test_single();
    test_signed();
    test_zero_len();
    test_backpressure();
    test_reset_midstream();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mac_job_scheduler.md
# mac_job_scheduler

Shares one `top_accelerator` MAC pipeline between `NREQ` requesters, each submitting dot-product jobs of up to `MAX_LEN` operand pairs. A round-robin arbiter selects a requester, clears the accumulator, streams that requester's operands into the accelerator's input FIFOs, counts `valid_out` pulses, then returns the signed result tagged with the requester ID. It sits between the requester fabric and `top_accelerator`, and is the only driver of the accelerator's `wr_en`, `din_a`, `din_b` and `acc_clr`.

## Interface
- `WIDTH`, 16, operand width; result is `2*WIDTH` signed.
- `NREQ`, 4, number of requesters (2..8).
- `MAX_LEN`, 16, maximum job length; `LENW = $clog2(MAX_LEN+1)`; `IDW = $clog2(NREQ)`.
- `clk`  in  1  single clock; all logic on posedge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `job_req`  in  NREQ  per-requester job request, level.
- `job_len`  in  NREQ*LENW  packed lengths; slice i belongs to requester i.
- `job_grant`  out  NREQ  one-hot, one-cycle grant pulse.
- `op_valid`  in  NREQ  per-requester operand-pair valid.
- `op_a`, `op_b`  in  NREQ*WIDTH each  packed operands.
- `op_ready`  out  NREQ  per-requester operand ready; at most one bit high.
- `res_valid`  out  1  result available.
- `res_id`  out  IDW  requester index of the result.
- `res_data`  out  2*WIDTH signed  dot-product result.
- `res_ready`  in  1  result consumer ready.
- `acc_wr_en`  out  1  to accelerator `wr_en`.
- `acc_din_a`, `acc_din_b`  out  WIDTH  to accelerator `din_a` / `din_b`.
- `acc_fifo_full`  in  1  from accelerator `fifo_full`.
- `acc_clr`  out  1  to accelerator `acc_clr`.
- `acc_out`  in  2*WIDTH signed  from accelerator `acc_out`.
- `acc_valid_out`  in  1  from accelerator `valid_out`.

## Operation
- States: IDLE, CLEAR, STREAM, DRAIN, RESULT.
- IDLE:
  - If any `job_req` bit is set, grant the first requester at or after `rr_ptr`, scanning upward with wrap-around.
  - Pulse `job_grant[i]` and latch `cur_id=i` and `cur_len=job_len[i]`.
  - Set `rr_ptr=i+1 mod NREQ`, then go to CLEAR.
- Requester obligations: drop `job_req` in the cycle after the grant. A request still held later is treated as a new job.
- CLEAR: drive `acc_clr=1` for exactly one cycle, zero the counters `sent` and `done`, then go to:
  - RESULT if `cur_len==0`, with `res_data=0`;
  - STREAM otherwise.
- STREAM:
  - Ready: `op_ready[cur_id] = !acc_fifo_full && sent<cur_len`. This path is combinational.
  - Transfer: `op_valid[cur_id] && op_ready[cur_id]` drives `acc_wr_en=1`, `acc_din_a/b` from slice `cur_id`, and increments `sent`.
  - When `sent` reaches `cur_len`, go to DRAIN.
- Outside transfers, `acc_wr_en=0` and `acc_din_a/b` hold 0.
- STREAM and DRAIN both count completions: each `acc_valid_out` cycle increments `done`.
- On the cycle `done` reaches `cur_len`, register `res_data<=acc_out`. `acc_out` is final in that cycle. Then go to RESULT.
- RESULT: hold `res_valid=1` with stable `res_id` and `res_data` until `res_ready`. The transfer cycle returns to IDLE.
- Arithmetic: no saturation; `res_data` is the accelerator's two's-complement wrap.
- Non-granted requesters always see `op_ready=0`. Operands offered without a grant are ignored.

## Timing
- Reset values: `job_grant=0`, `op_ready=0`, `res_valid=0`, `res_id=0`, `res_data=0`, `acc_wr_en=0`, `acc_din_a=0`, `acc_din_b=0`, `acc_clr=0`, `rr_ptr=0`, state IDLE.
- Reset mid-operation: abort the job immediately and return all outputs to reset values. The accelerator shares `rst_n`, so it is flushed as well.
- Grant comes 1 cycle after `job_req` is sampled in IDLE. `acc_clr` follows in the next cycle.
- First `op_ready` comes 1 cycle after `acc_clr`, so the clear always precedes the first write.
- Best-case job latency, from grant to `res_valid`: `cur_len + 5` cycles.
- No new grant is issued until the RESULT handshake completes (one job in flight).
- `acc_fifo_full` deasserts `op_ready` in the same cycle.
- `res_valid && res_ready` in the same cycle that `job_req` is asserted: the new request is arbitrated in the following IDLE cycle.

## Test plan
- Single job, requester 0, len 3, a=(1,2,3), b=(4,5,6) -> one `acc_clr` pulse, three `acc_wr_en` pulses, then `res_valid` with `res_id=0`, `res_data=32`.
- Signed job, len 2, a=(-2,7), b=(3,-1) -> `res_data=-13` (0xFFFFFFF3).
- Round-robin: all four requesters hold `job_req` with len 1 -> grant order 0,1,2,3. Requester 0 then re-requests -> it is granted only after 3.
- `job_len=0` -> CLEAR then RESULT with `res_data=0`; no `acc_wr_en`.
- Backpressure: force `acc_fifo_full=1` for 5 cycles mid-stream, and hold `res_ready=0` for 4 cycles -> no writes while full; `res_valid`, `res_id` and `res_data` stay stable; the sum is still correct.
- Assert `rst_n=0` during STREAM with `sent=2` of 5 -> all outputs reach reset values. A fresh len-1 job (3×3) afterwards yields 9.
